// File: rtl/id_ex_reg_b.sv
// Lane-B ID/EX pipeline register with stall, flush-to-bubble and a saturating
// count of valid instructions discarded by flush.
module id_ex_reg_b #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             StallB_E,
   input  logic             FlushB_E,
   input  logic             ValidB_D,
   input  logic [XLEN-1:0]  RD1B_D,
   input  logic [XLEN-1:0]  RD2B_D,
   input  logic [4:0]       Rs1B_D,
   input  logic [4:0]       Rs2B_D,
   input  logic [4:0]       RdB_D,
   input  logic [XLEN-1:0]  ImmExtB_D,
   input  logic [XLEN-1:0]  PCB_D,
   input  logic [XLEN-1:0]  PCPlus4B_D,
   input  logic             RegWriteB_D,
   input  logic             MemWriteB_D,
   input  logic             ALUSrcB_D,
   input  logic             BranchB_D,
   input  logic             JumpB_D,
   input  logic [1:0]       ResultSrcB_D,
   input  logic [2:0]       ALUControlB_D,
   output logic             ValidB_E,
   output logic [XLEN-1:0]  RD1B_E,
   output logic [XLEN-1:0]  RD2B_E,
   output logic [4:0]       Rs1B_E,
   output logic [4:0]       Rs2B_E,
   output logic [4:0]       RdB_E,
   output logic [XLEN-1:0]  ImmExtB_E,
   output logic [XLEN-1:0]  PCB_E,
   output logic [XLEN-1:0]  PCPlus4B_E,
   output logic             RegWriteB_E,
   output logic             MemWriteB_E,
   output logic             ALUSrcB_E,
   output logic             BranchB_E,
   output logic             JumpB_E,
   output logic [1:0]       ResultSrcB_E,
   output logic [2:0]       ALUControlB_E,
   output logic [CNT_W-1:0] FlushCntB
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // NOTE: every register here is sequential state, so it is assigned with <=
   // only; a blocking assignment would let later statements see the new value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ValidB_E      <= 1'b0;
         RD1B_E        <= '0;
         RD2B_E        <= '0;
         Rs1B_E        <= '0;
         Rs2B_E        <= '0;
         RdB_E         <= '0;
         ImmExtB_E     <= '0;
         PCB_E         <= '0;
         PCPlus4B_E    <= '0;
         RegWriteB_E   <= 1'b0;
         MemWriteB_E   <= 1'b0;
         ALUSrcB_E     <= 1'b0;
         BranchB_E     <= 1'b0;
         JumpB_E       <= 1'b0;
         ResultSrcB_E  <= '0;
         ALUControlB_E <= '0;
         FlushCntB     <= '0;
      end else if (FlushB_E) begin
         // Bubble with all-zero register indices so forwarding can only match x0.
         ValidB_E      <= 1'b0;
         RD1B_E        <= '0;
         RD2B_E        <= '0;
         Rs1B_E        <= '0;
         Rs2B_E        <= '0;
         RdB_E         <= '0;
         ImmExtB_E     <= '0;
         PCB_E         <= '0;
         PCPlus4B_E    <= '0;
         RegWriteB_E   <= 1'b0;
         MemWriteB_E   <= 1'b0;
         ALUSrcB_E     <= 1'b0;
         BranchB_E     <= 1'b0;
         JumpB_E       <= 1'b0;
         ResultSrcB_E  <= '0;
         ALUControlB_E <= '0;
         if (ValidB_D && FlushCntB != CNT_MAX)
            FlushCntB <= FlushCntB + CNT_ONE;
      end else if (!StallB_E) begin
         ValidB_E      <= ValidB_D;
         RD1B_E        <= RD1B_D;
         RD2B_E        <= RD2B_D;
         Rs1B_E        <= Rs1B_D;
         Rs2B_E        <= Rs2B_D;
         RdB_E         <= RdB_D;
         ImmExtB_E     <= ImmExtB_D;
         PCB_E         <= PCB_D;
         PCPlus4B_E    <= PCPlus4B_D;
         // An empty slot must never write state or redirect the PC.
         RegWriteB_E   <= RegWriteB_D & ValidB_D;
         MemWriteB_E   <= MemWriteB_D & ValidB_D;
         ALUSrcB_E     <= ALUSrcB_D;
         BranchB_E     <= BranchB_D & ValidB_D;
         JumpB_E       <= JumpB_D & ValidB_D;
         ResultSrcB_E  <= ResultSrcB_D;
         ALUControlB_E <= ALUControlB_D;
      end
   end

endmodule

// File: doc/id_ex_reg_b.md
ID_EX_REG_B -- requirements
Module: id_ex_reg_b

Interface
REQ-001 Parameter: XLEN, 32, width of data, PC and immediate fields.
REQ-002 Parameter: CNT_W, 16, width of the flushed-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-005 StallB_E  input  1  hold current EX-stage contents for lane B.
REQ-006 FlushB_E  input  1  replace EX-stage contents with a bubble on the next edge.
REQ-007 ValidB_D  input  1  decode-stage lane-B slot holds a real instruction.
REQ-008 RD1B_D, RD2B_D  input  XLEN each  register-file read data, operands 1 and 2.
REQ-009 Rs1B_D, Rs2B_D, RdB_D  input  5 each  source and destination register indices.
REQ-010 ImmExtB_D, PCB_D, PCPlus4B_D  input  XLEN each  extended immediate, PC, PC+4.
REQ-011 RegWriteB_D, MemWriteB_D, ALUSrcB_D, BranchB_D, JumpB_D  input  1 each  decoded control bits.
REQ-012 ResultSrcB_D  input  2  result select; ALUControlB_D  input  3  ALU operation.
REQ-013 Every D-suffixed input has an E-suffixed registered output of identical width (ValidB_E, RD1B_E, RD2B_E, Rs1B_E, Rs2B_E, RdB_E, ImmExtB_E, PCB_E, PCPlus4B_E, RegWriteB_E, MemWriteB_E, ALUSrcB_E, BranchB_E, JumpB_E, ResultSrcB_E, ALUControlB_E).
REQ-014 FlushCntB  output  CNT_W  number of valid lane-B instructions discarded by flush.

Function
REQ-015 Latency: a D-stage value SHALL appear on its E output exactly one clk edge after capture; no combinational path from any input to any output.
REQ-016 Per edge, priority SHALL be: reset > FlushB_E > StallB_E > load.
REQ-017 Load (no flush, no stall): every E register SHALL take its D input.
REQ-018 Stall (StallB_E=1, FlushB_E=0): every E register SHALL hold its value, including ValidB_E and FlushCntB.
REQ-019 Flush (FlushB_E=1, regardless of StallB_E): ValidB_E, RegWriteB_E, MemWriteB_E, BranchB_E, JumpB_E SHALL become 0; all other E fields SHALL become 0 as well, so Rs1B_E/Rs2B_E/RdB_E=0 give the forwarding logic no match except x0.
REQ-020 A bubble (ValidB_E=0) SHALL never assert RegWriteB_E or MemWriteB_E; on load with ValidB_D=0, RegWriteB_E, MemWriteB_E, BranchB_E, JumpB_E SHALL be forced to 0 while data fields load normally.
REQ-021 FlushCntB SHALL increment by 1 on an edge where FlushB_E=1 and ValidB_D=1 (a real instruction is discarded).
REQ-022 FlushCntB SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-023 Simultaneous StallB_E=1 and FlushB_E=1 SHALL behave as flush (REQ-019) and count per REQ-021.
REQ-024 Signals SHALL be zero-based widths exactly as declared; no sign or width conversion of data fields.

Reset
REQ-025 While reset=1, all outputs SHALL be 0, including FlushCntB, independent of clk.
REQ-026 Reset asserted mid-stall or mid-flush SHALL clear state immediately; first edge after deassertion SHALL follow REQ-016 normally.

Verification
REQ-027 Reset: drive all D inputs nonzero, pulse reset between edges -> all E outputs and FlushCntB read 0 before next edge.
REQ-028 Load: RD1B_D=32'hDEADBEEF, RdB_D=5'd7, RegWriteB_D=1, ValidB_D=1, no stall/flush -> after one edge RD1B_E=32'hDEADBEEF, RdB_E=7, RegWriteB_E=1, ValidB_E=1.
REQ-029 Stall: after REQ-028, StallB_E=1 for 3 edges with RD1B_D=32'h1 -> RD1B_E stays 32'hDEADBEEF; StallB_E=0 -> next edge RD1B_E=32'h1.
REQ-030 Flush priority: StallB_E=1, FlushB_E=1, ValidB_D=1, RegWriteB_D=1 -> next edge ValidB_E=0, RegWriteB_E=0, RdB_E=0, FlushCntB=1.
REQ-031 Invalid slot: ValidB_D=0, MemWriteB_D=1, RD2B_D=32'h55 -> next edge MemWriteB_E=0, RD2B_E=32'h55, FlushCntB unchanged.
REQ-032 Saturation with CNT_W=2: four flushes of valid instructions -> FlushCntB reads 1,2,3,3.
